// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian words -> imem writes, then checksum-gated CPU release.
// Latency: write strobe one cycle after a word's 4th byte; done/cpu_reset settle one cycle after the checksum byte. No backpressure while loading.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_t;

  localparam logic [16:0]     CAP = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [7:0]        hdr_hi_q;
  logic [ADDR_W:0]   n_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  // Only the first three bytes of a word need storing; the 4th arrives with the write.
  logic [23:0]       asm_q;
  logic [7:0]        csum_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic [15:0] n_full;
  logic        last_byte;

  assign accept    = rx_valid && rx_ready;
  assign n_full    = {hdr_hi_q, rx_data};
  assign last_byte = (byte_cnt_q == 2'd3) && (word_cnt_q == (n_q - ONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_HDR_HI;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: if (accept) state_d = S_HDR_LO;
      S_HDR_LO: if (accept) begin
        if (n_full == 16'd0)               state_d = S_CSUM;
        else if ({1'b0, n_full} > CAP)     state_d = S_ERR;
        else                               state_d = S_DATA;
      end
      S_DATA:   if (accept && last_byte) state_d = S_CSUM;
      S_CSUM:   if (accept) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    rx_ready  = reset && ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM));
    done      = (state_q == S_RUN);
    err       = (state_q == S_ERR);
    cpu_reset = (state_q != S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_hi_q   <= '0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HDR_HI: hdr_hi_q <= rx_data;
          S_HDR_LO: n_q      <= n_full[ADDR_W:0];
          S_DATA: begin
            asm_q      <= {asm_q[15:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            csum_q     <= csum_q ^ rx_data;
            if (byte_cnt_q == 2'd3) begin
              we_q       <= 1'b1;
              addr_q     <= word_cnt_q[ADDR_W-1:0];
              wdata_q    <= {asm_q, rx_data};
              word_cnt_q <= word_cnt_q + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the pipelined CPU. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses from 0x00. It holds the CPU in reset until the image is loaded and its checksum matches, then releases the core. It is the hardware counterpart of the hierarchical memory preloading used in simulation.

## Interface

- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready at posedge.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- cpu_reset  out  1  active-high reset to the pipelined datapath; held high until a successful load.
- done  out  1  load completed, checksum good, CPU running.
- err  out  1  load failed; the CPU stays in reset.

## Operation

- Stream format:
  - 2-byte word count N, big-endian.
  - N×4 data bytes; each word is sent MSB first.
  - 1 checksum byte, equal to the XOR of all data bytes. The header is excluded from the checksum.
- States:
  - HDR_HI: capture N[15:8]; go to HDR_LO.
  - HDR_LO: capture N[7:0].
    - N == 0: go to CSUM.
    - N > 2^ADDR_W: go to ERROR.
    - Otherwise: go to DATA.
  - DATA:
    - Shift each byte into a 32-bit assembly register, MSB first.
    - Track a 2-bit byte counter and an ADDR_W+1-bit word counter.
    - XOR each byte into an 8-bit running checksum.
    - On the 4th byte of a word, latch the completed word into imem_wdata and the word index into imem_addr, and set imem_we for the following cycle.
    - After word N-1 completes, go to CSUM.
  - CSUM:
    - Byte equals the running checksum: go to RUN.
    - Otherwise: go to ERROR.
  - RUN: done=1, cpu_reset=0. rx_ready=0. Terminal until reset.
  - ERROR: err=1, cpu_reset=1. rx_ready=0. Terminal until reset.
- rx_ready is 1 in HDR_HI, HDR_LO, DATA and CSUM. It is 0 in RUN and ERROR, and 0 while reset is low.
- Bytes presented with rx_valid=0 are ignored, and all counters hold.
- There is no backpressure during word writes. The next word's byte may be accepted in the same cycle imem_we is high, because the assembly register and the write registers are separate.
- Byte and word counters never wrap; the state transitions terminate loading first.
- When N == 2^ADDR_W, the last write goes to address 2^ADDR_W-1.

## Timing

- Reset values: rx_ready=0 while reset is low, then 1 in HDR_HI.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, err=0.
  - All counters and the checksum are 0; state is HDR_HI.
- Reset asserted mid-load: all outputs return asynchronously to their reset values. The partial image already written to memory is left in place but never executed; a full reload is required.
- Write latency: imem_we is high exactly one cycle, in the cycle after the posedge that accepts a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle.
- Release latency: the checksum byte is accepted at posedge k. At posedge k the state becomes RUN.
  - From then on, registered done=1 and cpu_reset=0, visible in cycle k+1.
  - The last word's imem_we is never simultaneous with the cpu_reset deassertion.
- ERROR entry: the rejecting byte is accepted at posedge k; err=1 from cycle k+1.
- Throughput: one byte per cycle is sustained. An N-word image loads in 4N+3 cycles at full rate.

## Test plan

- Load 3 words (0xF340_7800, 0xF38_05800, 0x4041_0800) at full rate with the correct checksum:
  - Three imem_we pulses at addresses 0, 1, 2 with the exact words.
  - done=1 and cpu_reset=0 one cycle after the checksum byte.
  - Total time 15 cycles.
- Same image with rx_valid toggled randomly: identical writes and identical release; no byte dropped or duplicated.
- Checksum byte deliberately wrong (correct value XOR 0x01): all 3 writes still occur; err=1, done=0, cpu_reset=1; rx_ready=0 afterwards.
- N=0, then checksum 0x00: no imem_we; done=1 after 3 accepted bytes. N=0 with checksum 0x5A: err=1.
- N=0x0101 with ADDR_W=8: err=1 in the cycle after the 2nd header byte; no imem_we ever.
- Assert reset during word 2 of a 4-word load:
  - Outputs return to their reset values immediately.
  - A subsequent full 4-word load writes addresses 0–3 and releases the CPU.
  - Run 29 words (0x1D) to show the full program size loads correctly.
